uart_prog_loader: RTL and testbench

//  UART serial program loader upstream of instruction/data memory; owns imem/dmem write port while core held in reset.

---
 rtl/uart_prog_loader.sv | 211 +++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART 8N1 program loader: fills imem lines and dmem words, then raises done.
// Optional trailing checksum byte when UART_PLOADER_CHKSUM_EN is defined.
module uart_prog_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_LEN     = 32
) (
   input  logic                clk,
   input  logic                reset_x,
   input  logic                rxd,
   output logic [ADDR_LEN-1:0] addr,
   output logic [127:0]        data,
   output logic                we_32,
   output logic                we_128,
   output logic                done,
   output logic                err
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT + 1);

   typedef enum logic [2:0] {
      R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
   } rx_state_t;

   typedef enum logic [2:0] {
      S_HDR_I, S_HDR_D, S_IMEM, S_DMEM, S_CHK, S_DONE
   } state_t;

`ifdef UART_PLOADER_CHKSUM_EN
   localparam state_t S_END = S_CHK;
`else
   localparam state_t S_END = S_DONE;
`endif

   logic          rxd_s1, rxd_s2;
   rx_state_t     rx_st, rx_n;
   logic [CW-1:0] cnt;
   logic [2:0]    bitn;
   logic [7:0]    shreg;
   logic          bv;
   logic          rx_err;
   logic          cnt_half, cnt_full;

   state_t        state, state_n;
   logic [3:0]    bcnt;
   logic [27:0]   icnt_r;
   logic [29:0]   dcnt_r;
   logic [7:0]    sum;
   logic [29:0]   dcnt_hdr;

   assign cnt_half = (cnt == CW'(HALF - 1));
   assign cnt_full = (cnt == CW'(CLKS_PER_BIT - 1));
   assign dcnt_hdr = {shreg, data[127:106]};
   assign done     = (state == S_DONE);

   // two-flop synchronizer for the asynchronous receive line
   always_ff @(posedge clk) begin
      if (!reset_x) begin
         rxd_s1 <= 1'b1;
         rxd_s2 <= 1'b1;
      end else begin
         rxd_s1 <= rxd;
         rxd_s2 <= rxd_s1;
      end
   end

   // receiver state register
   always_ff @(posedge clk) begin
      if (!reset_x) rx_st <= R_IDLE;
      else          rx_st <= rx_n;
   end

   // receiver next state: mid-bit sampling, glitch reject, stop check
   always_comb begin
      rx_n = rx_st;
      unique case (rx_st)
         R_IDLE:  if (!rxd_s2) rx_n = R_START;
         R_START: if (cnt_half) rx_n = rxd_s2 ? R_IDLE : R_DATA;
         R_DATA:  if (cnt_full && bitn == 3'd7) rx_n = R_STOP;
         R_STOP:  if (cnt_full) rx_n = rxd_s2 ? R_IDLE : R_WAIT;
         R_WAIT:  if (rxd_s2) rx_n = R_IDLE;
         default: rx_n = R_IDLE;
      endcase
   end

   // receiver datapath: bit timer, shift register, byte/error pulses
   always_ff @(posedge clk) begin
      if (!reset_x) begin
         cnt    <= '0;
         bitn   <= '0;
         shreg  <= '0;
         bv     <= 1'b0;
         rx_err <= 1'b0;
      end else begin
         bv     <= 1'b0;
         rx_err <= 1'b0;
         if (rx_n != rx_st || cnt_full) cnt <= '0;
         else                           cnt <= cnt + 1'b1;
         if (rx_st == R_DATA && cnt_full) begin
            shreg <= {rxd_s2, shreg[7:1]};
            bitn  <= bitn + 3'd1;
         end
         if (rx_st == R_STOP && cnt_full) begin
            bv     <= rxd_s2;
            rx_err <= !rxd_s2;
         end
      end
   end

   // loader state register
   always_ff @(posedge clk) begin
      if (!reset_x) state <= S_HDR_I;
      else          state <= state_n;
   end

   // loader next state; payload phases end after their last strobe
   always_comb begin
      state_n = state;
      unique case (state)
         S_HDR_I: if (bv && bcnt == 4'd3) state_n = S_HDR_D;
         S_HDR_D: begin
            if (bv && bcnt == 4'd3) begin
               if (icnt_r != '0)        state_n = S_IMEM;
               else if (dcnt_hdr != '0) state_n = S_DMEM;
               else                     state_n = S_END;
            end
         end
         S_IMEM: begin
            if (we_128 && icnt_r == '0)
               state_n = (dcnt_r != '0) ? S_DMEM : S_END;
         end
         S_DMEM:  if (we_32 && dcnt_r == '0) state_n = S_END;
         S_CHK:   if (bv) state_n = S_DONE;
         S_DONE:  state_n = S_DONE;
         default: state_n = S_HDR_I;
      endcase
   end

   // loader datapath: byte packing, counters, strobes, address, err
   always_ff @(posedge clk) begin
      if (!reset_x) begin
         addr   <= '0;
         data   <= '0;
         we_32  <= 1'b0;
         we_128 <= 1'b0;
         err    <= 1'b0;
         bcnt   <= '0;
         icnt_r <= '0;
         dcnt_r <= '0;
         sum    <= '0;
      end else begin
         we_32  <= 1'b0;
         we_128 <= 1'b0;
         if (rx_err) err <= 1'b1;
         if (bv && state != S_CHK && state != S_DONE)
            sum <= sum + shreg;
         unique case (state)
            S_HDR_I: begin
               if (bv) begin
                  data <= {shreg, data[127:8]};
                  bcnt <= bcnt + 4'd1;
                  if (bcnt == 4'd3) icnt_r <= {shreg, data[127:108]};
               end
            end
            S_HDR_D: begin
               if (bv) begin
                  data <= {shreg, data[127:8]};
                  bcnt <= bcnt + 4'd1;
                  if (bcnt == 4'd3) dcnt_r <= dcnt_hdr;
               end
            end
            S_IMEM: begin
               if (bv) begin
                  data <= {shreg, data[127:8]};
                  bcnt <= bcnt + 4'd1;
                  if (bcnt == 4'd15) begin
                     we_128 <= 1'b1;
                     icnt_r <= icnt_r - 28'd1;
                  end
               end
               if (we_128) addr <= addr + ADDR_LEN'(16);
            end
            S_DMEM: begin
               if (bv) begin
                  data <= {shreg, data[127:8]};
                  if (bcnt == 4'd3) begin
                     bcnt   <= '0;
                     we_32  <= 1'b1;
                     dcnt_r <= dcnt_r - 30'd1;
                  end else begin
                     bcnt <= bcnt + 4'd1;
                  end
               end
               if (we_32) addr <= addr + ADDR_LEN'(4);
            end
            S_CHK: begin
               if (bv && shreg != sum) err <= 1'b1;
            end
            default: ;
         endcase
         if (state_n != state) begin
            bcnt <= '0;
            if (state_n == S_IMEM || state_n == S_DMEM)
               data <= '0;
            if (state_n == S_DMEM)
               addr <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed frames plus
// random frames checked against a queue-based write model.
module tb_uart_prog_loader;

   localparam int CPB = 8;

   logic         clk = 1'b0;
   logic         reset_x = 1'b0;
   logic         rxd = 1'b1;
   logic [31:0]  addr;
   logic [127:0] data;
   logic         we_32, we_128, done, err;

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_LEN(32)) dut (
      .clk(clk), .reset_x(reset_x), .rxd(rxd),
      .addr(addr), .data(data), .we_32(we_32),
      .we_128(we_128), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           is_i;
      logic [31:0]  a;
      logic [127:0] d;
   } wr_t;

   int         vecs = 0;
   int         errs = 0;
   wr_t        exp_q[$];
   logic [7:0] frame[$];
   bit         prev_we = 1'b0;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] expv);
      vecs++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // compare every write strobe against the model queue
   always @(negedge clk) begin
      if (we_128 || we_32) begin
         wr_t e;
         chk("we_exclusive", 128'(we_128 & we_32), 128'd0);
         chk("we_one_cycle", 128'(prev_we), 128'd0);
         chk("write_expected", 128'(exp_q.size() != 0), 128'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_kind", 128'(we_128), 128'(e.is_i));
            chk("wr_addr", 128'(addr), 128'(e.a));
            if (e.is_i) chk("imem_data", data, e.d);
            else chk("dmem_data", 128'(data[127:96]), 128'(e.d[127:96]));
         end
      end
      prev_we = we_128 | we_32;
   end

   task automatic send_byte(input logic [7:0] b, input bit stop);
      rxd = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(posedge clk);
      end
      rxd = stop;
      repeat (CPB) @(posedge clk);
      rxd = 1'b1;
      repeat (CPB) @(posedge clk);
   endtask

   task automatic send_range(input int first, input int last);
      for (int i = first; i < last; i++) send_byte(frame[i], 1'b1);
   endtask

   task automatic check_reset_vals();
      @(negedge clk);
      chk("rst_addr", 128'(addr), 128'd0);
      chk("rst_data", data, 128'd0);
      chk("rst_we32", 128'(we_32), 128'd0);
      chk("rst_we128", 128'(we_128), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
   endtask

   task automatic do_reset();
      exp_q.delete();
      rxd = 1'b1;
      reset_x = 1'b0;
      repeat (3) @(posedge clk);
      check_reset_vals();
      @(posedge clk);
      reset_x = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   // header, payload of whole lines/words (random), optional checksum
   task automatic build_frame(input int unsigned icnt,
                              input int unsigned dcnt);
      int n;
      frame.delete();
      for (int i = 0; i < 4; i++) frame.push_back(8'(icnt >> (8 * i)));
      for (int i = 0; i < 4; i++) frame.push_back(8'(dcnt >> (8 * i)));
      n = (icnt / 16) * 16 + (dcnt / 4) * 4;
      for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
      add_chksum();
   endtask

   task automatic add_chksum();
`ifdef UART_PLOADER_CHKSUM_EN
      logic [7:0] s;
      s = 8'd0;
      foreach (frame[i]) s = s + frame[i];
      frame.push_back(s);
`endif
   endtask

   // expected writes derived from the frame contents alone
   function automatic void model_frame();
      int unsigned icnt, dcnt;
      int p;
      wr_t e;
      icnt = {frame[3], frame[2], frame[1], frame[0]};
      dcnt = {frame[7], frame[6], frame[5], frame[4]};
      p = 8;
      for (int l = 0; l < int'(icnt / 16); l++) begin
         e.is_i = 1'b1;
         e.a = 32'(16 * l);
         e.d = '0;
         for (int j = 0; j < 16; j++) begin
            e.d[8*j +: 8] = frame[p];
            p++;
         end
         exp_q.push_back(e);
      end
      for (int w = 0; w < int'(dcnt / 4); w++) begin
         e.is_i = 1'b0;
         e.a = 32'(4 * w);
         e.d = '0;
         for (int j = 0; j < 4; j++) begin
            e.d[96 + 8*j +: 8] = frame[p];
            p++;
         end
         exp_q.push_back(e);
      end
   endfunction

   task automatic check_end(input string name, input bit exp_err);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 20 * CPB) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk({name, "_done"}, 128'(done), 128'd1);
      chk({name, "_err"}, 128'(err), 128'(exp_err));
      chk({name, "_left"}, 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      wr_t e;
      int unsigned ic, dc;
      reset_x = 1'b0;
      repeat (4) @(posedge clk);
      check_reset_vals();
      reset_x = 1'b1;
      repeat (2) @(posedge clk);

      // T1: hand-computed line and word
      frame.delete();
      frame = '{8'd16, 8'd0, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd0};
      for (int i = 0; i < 16; i++) frame.push_back(8'(i));
      frame.push_back(8'hAA);
      frame.push_back(8'hBB);
      frame.push_back(8'hCC);
      frame.push_back(8'hDD);
      add_chksum();
      e.is_i = 1'b1;
      e.a = 32'h0;
      e.d = 128'h0F0E0D0C0B0A09080706050403020100;
      exp_q.push_back(e);
      e.is_i = 1'b0;
      e.a = 32'h0;
      e.d = {32'hDDCCBBAA, 96'h0};
      exp_q.push_back(e);
      send_range(0, frame.size());
      check_end("t1", 1'b0);

      // T2: empty program, done right after the last frame byte
      do_reset();
      build_frame(0, 0);
      send_range(0, frame.size() - 1);
      @(negedge clk);
      chk("t2_done_early", 128'(done), 128'd0);
      send_range(frame.size() - 1, frame.size());
      @(negedge clk);
      chk("t2_done_now", 128'(done), 128'd1);
      check_end("t2", 1'b0);

      // T3: two lines, two words
      do_reset();
      build_frame(32, 8);
      model_frame();
      send_range(0, frame.size());
      check_end("t3", 1'b0);

      // T4: glitch ignored, framing error sets err, then normal frame
      do_reset();
      rxd = 1'b0;
      repeat (CPB / 4) @(posedge clk);
      rxd = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      send_byte(8'h5A, 1'b0);
      @(negedge clk);
      chk("t4_err", 128'(err), 128'd1);
      build_frame(16, 4);
      model_frame();
      send_range(0, frame.size());
      check_end("t4", 1'b1);

      // T5: reset mid-payload, then full resend
      do_reset();
      build_frame(16, 4);
      model_frame();
      send_range(0, 18);
      do_reset();
      model_frame();
      send_range(0, frame.size());
      check_end("t5", 1'b0);

      // random frames, including unaligned counts and zero sizes
      for (int r = 0; r < 4; r++) begin
         do_reset();
         ic = $urandom_range(0, 3) * 16 + $urandom_range(0, 15);
         dc = $urandom_range(0, 5) * 4 + $urandom_range(0, 3);
         build_frame(ic, dc);
         model_frame();
         send_range(0, frame.size());
         check_end("rand", 1'b0);
      end

`ifdef UART_PLOADER_CHKSUM_EN
      // T6: corrupted checksum still completes, with err
      do_reset();
      build_frame(16, 4);
      model_frame();
      frame[frame.size() - 1] = frame[frame.size() - 1] + 8'd1;
      send_range(0, frame.size());
      check_end("t6", 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
